// File: rtl/mem_checker_csr.sv
// Memory checker control/status register file.
// Avalon-MM slave: test config, start pulse, status, error capture.
module mem_checker_csr #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              amm_read_i,
  input  logic              amm_write_i,
  input  logic [ADDR_W-1:0] amm_address_i,
  input  logic [DATA_W-1:0] amm_writedata_i,
  output logic [DATA_W-1:0] amm_readdata_o,
  output logic              start_o,
  output logic [1:0]        test_mode_o,
  output logic [DATA_W-1:0] start_addr_o,
  output logic [DATA_W-1:0] length_o,
  input  logic              done_i,
  input  logic              err_i,
  input  logic [DATA_W-1:0] err_addr_i
);

  localparam logic [ADDR_W-1:0] A_CTRL  = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_MODE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_SADDR = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_LEN   = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] A_STAT  = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] A_ECNT  = ADDR_W'(5);
  localparam logic [ADDR_W-1:0] A_EADDR = ADDR_W'(6);
  localparam logic [ADDR_W-1:0] A_TICKS = ADDR_W'(7);
  localparam logic [DATA_W-1:0] ONES    = '1;

  logic              busy;
  logic              done_f;
  logic              err_f;
  logic [DATA_W-1:0] err_cnt;
  logic [DATA_W-1:0] first_err;
  logic [DATA_W-1:0] ticks;

  logic              wr_ok;
  logic              start_req;
  logic              clr_req;
  logic              stray;
  logic              rd_status;
  logic              err_hit;
  logic [DATA_W-1:0] rd_mux;

  always_comb begin
    wr_ok     = amm_write_i && !busy;
    start_req = wr_ok && amm_address_i == A_CTRL
                && amm_writedata_i[0];
    clr_req   = wr_ok && amm_address_i == A_CTRL
                && amm_writedata_i[1];
    stray     = start_o && done_i;
    rd_status = amm_read_i && amm_address_i == A_STAT;
    err_hit   = busy && err_i;
  end

  always_comb begin
    rd_mux = '0;
    unique case (1'b1)
      amm_address_i == A_MODE:  rd_mux = DATA_W'(test_mode_o);
      amm_address_i == A_SADDR: rd_mux = start_addr_o;
      amm_address_i == A_LEN:   rd_mux = length_o;
      amm_address_i == A_STAT:
        rd_mux = DATA_W'({err_f, done_f, busy});
      amm_address_i == A_ECNT:  rd_mux = err_cnt;
      amm_address_i == A_EADDR: rd_mux = first_err;
      amm_address_i == A_TICKS: rd_mux = ticks;
      default:                  rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      amm_readdata_o <= '0;
      start_o        <= 1'b0;
      test_mode_o    <= '0;
      start_addr_o   <= '0;
      length_o       <= '0;
      busy           <= 1'b0;
      done_f         <= 1'b0;
      err_f          <= 1'b0;
      err_cnt        <= '0;
      first_err      <= '0;
      ticks          <= '0;
    end else begin
      start_o <= start_req;
      if (amm_read_i)
        amm_readdata_o <= rd_mux;
      if (wr_ok && amm_address_i == A_MODE)
        test_mode_o <= amm_writedata_i[1:0];
      if (wr_ok && amm_address_i == A_SADDR)
        start_addr_o <= amm_writedata_i;
      if (wr_ok && amm_address_i == A_LEN)
        length_o <= amm_writedata_i;
      if (busy && ticks != ONES)
        ticks <= ticks + DATA_W'(1);
      if (clr_req) begin
        err_cnt   <= '0;
        first_err <= '0;
        ticks     <= '0;
      end
      if (err_hit) begin
        if (err_cnt != ONES)
          err_cnt <= err_cnt + DATA_W'(1);
        if (!err_f)
          first_err <= err_addr_i;
      end
      // flag clears come first so a coinciding set wins
      if (clr_req || rd_status) begin
        done_f <= 1'b0;
        err_f  <= 1'b0;
      end
      if (err_hit)
        err_f <= 1'b1;
      if (done_i && !stray) begin
        done_f <= 1'b1;
        busy   <= 1'b0;
      end
      if (start_req)
        busy <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_checker_csr.sv
// Bench for mem_checker_csr: register-level model plus
// directed vectors with literal expectations.
module tb_mem_checker_csr;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        rd = 1'b0, wr = 1'b0;
  logic [3:0]  addr = '0;
  logic [31:0] wd = '0;
  logic        done = 1'b0, err = 1'b0;
  logic [31:0] eaddr = '0;
  logic [31:0] rdata, sa_o, len_o;
  logic [1:0]  mode_o;
  logic        start;

  logic        s_rd = 1'b0, s_wr = 1'b0;
  logic [3:0]  s_addr = '0, s_wd = '0, s_ea = '0;
  logic        s_done = 1'b0, s_err = 1'b0;
  logic [3:0]  s_rdata, s_sa, s_len;
  logic [1:0]  s_mode;
  logic        s_start;

  mem_checker_csr #(.ADDR_W(4), .DATA_W(32)) dut (
    .clk_i(clk), .rst_i(rst),
    .amm_read_i(rd), .amm_write_i(wr),
    .amm_address_i(addr), .amm_writedata_i(wd),
    .amm_readdata_o(rdata), .start_o(start),
    .test_mode_o(mode_o), .start_addr_o(sa_o),
    .length_o(len_o), .done_i(done), .err_i(err),
    .err_addr_i(eaddr)
  );

  mem_checker_csr #(.ADDR_W(4), .DATA_W(4)) sdut (
    .clk_i(clk), .rst_i(rst),
    .amm_read_i(s_rd), .amm_write_i(s_wr),
    .amm_address_i(s_addr), .amm_writedata_i(s_wd),
    .amm_readdata_o(s_rdata), .start_o(s_start),
    .test_mode_o(s_mode), .start_addr_o(s_sa),
    .length_o(s_len), .done_i(s_done), .err_i(s_err),
    .err_addr_i(s_ea)
  );

  int errors = 0;
  int checks = 0;
  bit chk_on = 1'b0;

  task automatic check(string name, logic [31:0] act,
                       logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // register-level model of the main instance
  logic        m_busy = 0, m_done = 0, m_err = 0, m_start = 0;
  logic [1:0]  m_mode = '0;
  logic [31:0] m_sa = '0, m_len = '0, m_cnt = '0;
  logic [31:0] m_first = '0, m_ticks = '0, m_rd = '0;
  logic        go, stray, new_err;

  function automatic logic [31:0] mval(logic [3:0] a);
    case (a)
      4'd1:    return {30'b0, m_mode};
      4'd2:    return m_sa;
      4'd3:    return m_len;
      4'd4:    return {29'b0, m_err, m_done, m_busy};
      4'd5:    return m_cnt;
      4'd6:    return m_first;
      4'd7:    return m_ticks;
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_busy = 0; m_done = 0; m_err = 0; m_start = 0;
      m_mode = '0; m_sa = '0; m_len = '0; m_cnt = '0;
      m_first = '0; m_ticks = '0; m_rd = '0;
    end else begin
      if (rd) m_rd = mval(addr);
      go = wr && !m_busy && addr == 4'd0 && wd[0];
      stray = m_start && done;
      new_err = m_busy && err;
      if (new_err) begin
        if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
        if (!m_err) m_first = eaddr;
      end
      if (m_busy && m_ticks != 32'hFFFF_FFFF)
        m_ticks = m_ticks + 1;
      if (wr && !m_busy) begin
        if (addr == 4'd0 && wd[1]) begin
          m_done = 0; m_err = 0; m_cnt = '0;
          m_first = '0; m_ticks = '0;
        end
        if (addr == 4'd1) m_mode = wd[1:0];
        if (addr == 4'd2) m_sa = wd;
        if (addr == 4'd3) m_len = wd;
      end
      if (rd && addr == 4'd4) begin
        m_done = 0; m_err = 0;
      end
      if (new_err) m_err = 1;
      if (done && !stray) begin
        m_done = 1; m_busy = 0;
      end
      if (go) m_busy = 1;
      m_start = go;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("mdl_start", start, m_start);
      check("mdl_mode", mode_o, m_mode);
      check("mdl_saddr", sa_o, m_sa);
      check("mdl_len", len_o, m_len);
      check("mdl_rdata", rdata, m_rd);
    end
  end

  task automatic cyc(bit r, bit w, logic [3:0] a,
                     logic [31:0] d, bit dn = 0, bit er = 0,
                     logic [31:0] ea = 0);
    rd = r; wr = w; addr = a; wd = d;
    done = dn; err = er; eaddr = ea;
    @(negedge clk);
    rd = 0; wr = 0; done = 0; err = 0;
  endtask

  task automatic wreg(logic [3:0] a, logic [31:0] d);
    cyc(0, 1, a, d);
  endtask

  task automatic rreg(string name, logic [3:0] a,
                      logic [31:0] exp);
    cyc(1, 0, a, 0);
    check(name, rdata, exp);
  endtask

  task automatic idle(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic scyc(bit r, bit w, logic [3:0] a,
                      logic [3:0] d, bit dn = 0, bit er = 0,
                      logic [3:0] ea = 0);
    s_rd = r; s_wr = w; s_addr = a; s_wd = d;
    s_done = dn; s_err = er; s_ea = ea;
    @(negedge clk);
    s_rd = 0; s_wr = 0; s_done = 0; s_err = 0;
  endtask

  task automatic srd(string name, logic [3:0] a,
                     logic [3:0] exp);
    scyc(1, 0, a, 0);
    check(name, s_rdata, exp);
  endtask

  initial begin
    @(negedge clk);
    chk_on = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    for (int a = 0; a < 8; a++) rreg("reset_rd", 4'(a), 0);

    wreg(2, 32'h1000);
    wreg(3, 32'h40);
    wreg(1, 32'h3);
    rreg("rb_saddr", 2, 32'h1000);
    rreg("rb_len", 3, 32'h40);
    rreg("rb_mode", 1, 32'h3);
    check("out_saddr", sa_o, 32'h1000);
    check("out_len", len_o, 32'h40);
    check("out_mode", mode_o, 2'h3);
    wreg(1, 32'hFFFF_FFFF);
    rreg("mode_mask", 1, 32'h3);

    wreg(0, 32'h1);
    check("start_hi", start, 1);
    wreg(2, 32'h5);
    check("start_lo", start, 0);
    wreg(0, 32'h1);
    check("no_restart", start, 0);
    rreg("stat_busy", 4, 32'h1);
    rreg("saddr_locked", 2, 32'h1000);
    idle(5);
    cyc(0, 0, 0, 0, 1);
    rreg("ticks10", 7, 32'd10);
    rreg("stat_done", 4, 32'h2);
    rreg("stat_clr", 4, 32'h0);

    wreg(0, 32'h1);
    idle(2);
    cyc(0, 0, 0, 0, 0, 1, 32'h1008);
    idle(1);
    cyc(0, 0, 0, 0, 0, 1, 32'h1010);
    cyc(0, 0, 0, 0, 0, 1, 32'h1018);
    cyc(0, 0, 0, 0, 1);
    rreg("err_cnt3", 5, 32'd3);
    rreg("first_err", 6, 32'h1008);
    rreg("stat_err", 4, 32'h6);
    cyc(0, 0, 0, 0, 0, 1, 32'h2000);
    rreg("err_idle", 5, 32'd3);

    cyc(1, 1, 1, 32'h2);
    check("rw_old", rdata, 32'h3);
    rreg("rw_new", 1, 32'h2);
    wreg(5, 32'h55);
    rreg("ro_write", 5, 32'd3);
    wreg(8, 32'hAB);
    rreg("rsvd_rd", 8, 32'h0);

    wreg(0, 32'h2);
    rreg("clr_cnt", 5, 0);
    rreg("clr_first", 6, 0);
    rreg("clr_ticks", 7, 0);
    rreg("clr_stat", 4, 0);

    cyc(1, 0, 4, 0, 1);
    check("stat_race", rdata, 32'h0);
    rreg("stat_race2", 4, 32'h2);
    wreg(0, 32'h3);
    check("clr_start", start, 1);
    rreg("clr_start_st", 4, 32'h1);
    cyc(0, 0, 0, 0, 1);
    rreg("clr_start_ticks", 7, 32'd2);

    wreg(0, 32'h1);
    check("pre_rst_start", start, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_start", start, 0);
    check("rst_saddr", sa_o, 0);
    for (int a = 0; a < 8; a++) rreg("rst_rd", 4'(a), 0);

    scyc(0, 1, 0, 4'h1);
    scyc(0, 0, 0, 0, 0, 1, 4'h9);
    for (int i = 0; i < 14; i++)
      scyc(0, 0, 0, 0, 0, 1, 4'h3);
    srd("sat_15", 5, 4'hF);
    scyc(0, 0, 0, 0, 0, 1, 4'h5);
    srd("sat_16", 5, 4'hF);
    srd("s_first", 6, 4'h9);
    scyc(0, 0, 0, 0, 1);
    scyc(0, 1, 0, 4'h2);
    srd("s_clr_cnt", 5, 0);
    srd("s_clr_first", 6, 0);
    srd("s_clr_ticks", 7, 0);
    srd("s_clr_stat", 4, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
